// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Single-port memory sequencer for fetch and load/store requesters
//            with timeout watchdog, fetch anti-starvation and core stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err,
    output logic          bus_err,
    output logic          stall
);

    localparam int c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam int c_streak_w = $clog2(MAX_STREAK + 1);
    localparam logic [c_cnt_w-1:0]    c_tmo_last   = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [c_cnt_w-1:0]    tcnt_q, tcnt_d;
    logic [c_streak_w-1:0] streak_q, streak_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic                  is_d_q, is_d_d;
    logic                  err_q, err_d;
    logic                  bus_err_q, bus_err_d;
    logic [DW-1:0]         if_rdata_q, if_rdata_d;
    logic [DW-1:0]         d_rdata_q, d_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            streak_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            is_d_q     <= 1'b0;
            err_q      <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            is_d_q     <= is_d_d;
            err_q      <= err_d;
            bus_err_q  <= bus_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        is_d_d     = is_d_q;
        err_d      = err_q;
        bus_err_d  = bus_err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                // Data wins unless fetch has already waited out a full streak.
                if (d_req && !(if_req && (streak_q == c_streak_max))) begin
                    state_d = D_ACC;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    is_d_d  = 1'b1;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != c_streak_max) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d  = IF_ACC;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    is_d_d   = 1'b0;
                    streak_d = '0;
                end
            end
            IF_ACC, D_ACC: begin
                tcnt_d = tcnt_q + 1'b1;
                if (mem_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (is_d_q) begin
                        d_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else if (tcnt_q == c_tmo_last) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    bus_err_d = 1'b1;
                    if (is_d_q) begin
                        d_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == IF_ACC) || (state_q == D_ACC);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = (state_q == RESP) && !is_d_q;
    assign d_done    = (state_q == RESP) && is_d_q;
    assign err       = (state_q == RESP) && err_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = (if_req && !if_done) || (d_req && !d_done);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 16;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_done, d_done;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err, bus_err, stall;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(TIMEOUT), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .bus_err(bus_err), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        ifq[$];
    exp_t        dq[$];
    logic [31:0] phys[logic [31:0]];
    logic [31:0] refm[logic [31:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    int          force_lat = -1;
    int          acc_cnt = 0;
    int          lat = 0;
    logic        sticky = 1'b0;
    logic        mreq_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address bit 16 marks a location that never answers; bit 15 one that
    // answers exactly on the last cycle before the watchdog would fire.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (acc_cnt == 0) begin
                if (mem_addr[16])        lat = 1000;
                else if (force_lat >= 0) lat = force_lat;
                else if (mem_addr[15])   lat = TIMEOUT - 1;
                else                     lat = $urandom_range(0, 4);
            end
            if (acc_cnt == lat) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    phys[mem_addr] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = phys.exists(mem_addr) ? phys[mem_addr] : init_val(mem_addr);
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt   = 0;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sticky    = 1'b0;
            mreq_prev = 1'b0;
        end else begin
            if (if_done && d_done) chk("both_done", 1, 0);
            if (if_done) begin
                if (ifq.size() == 0) chk("if_done_unexpected", 1, 0);
                else begin
                    e = ifq.pop_front();
                    sticky |= e.err;
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("if_err", err, e.err);
                    chk("if_bus_err", bus_err, sticky);
                end
            end
            if (d_done) begin
                if (dq.size() == 0) chk("d_done_unexpected", 1, 0);
                else begin
                    e = dq.pop_front();
                    sticky |= e.err;
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", err, e.err);
                    chk("d_bus_err", bus_err, sticky);
                end
            end
            if (mem_req && !mreq_prev)
                chk("mem_access_match",
                    (if_req && !mem_we && mem_addr == if_addr) ||
                    (d_req && mem_we == d_we && mem_addr == d_addr &&
                     (!d_we || mem_wdata == d_wdata)), 1);
            mreq_prev = mem_req;
        end
    end

    task automatic raise_if(input logic [31:0] a);
        exp_t e;
        e.err   = a[16];
        e.rdata = a[16] ? 32'h0 : ref_rd(a);
        ifq.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.err   = a[16];
        e.rdata = (a[16] || we) ? 32'h0 : ref_rd(a);
        if (!a[16] && we) refm[a] = wd;
        dq.push_back(e);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
    endtask

    task automatic wait_done(input bit is_d, output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (is_d ? d_done : if_done) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk(is_d ? "d_done_wait_expired" : "if_done_wait_expired", 0, 1);
    endtask

    task automatic rand_fetch();
        int n;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = 32'h1000 | ($urandom & 32'hFC);
            if ($urandom_range(0, 15) == 0) a |= 32'h10000;
            if ($urandom_range(0, 15) == 0) a |= 32'h8000;
            raise_if(a);
            wait_done(1'b0, n);
            @(posedge clk); #1;
            if_req = 1'b0;
        end
    endtask

    task automatic rand_data();
        int n;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = 32'h4000 | ($urandom & 32'h3C);
            if ($urandom_range(0, 15) == 0) a |= 32'h10000;
            if ($urandom_range(0, 15) == 0) a |= 32'h8000;
            raise_d(1'($urandom_range(0, 1)), a, $urandom);
            wait_done(1'b1, n);
            @(posedge clk); #1;
            d_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n, nd, nreq;
        bit got;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {mem_req, mem_we, if_done, d_done, err, bus_err, stall}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);
        @(posedge clk); #1; reset = 1'b0;

        // Fetch only, memory answers on the first access cycle.
        force_lat = 0;
        phys[32'h40] = 32'hDEAD_BEEF;
        refm[32'h40] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        raise_if(32'h40);
        @(negedge clk);
        chk("fetch_c0_stall", {stall, mem_req}, 2'b10);
        @(negedge clk);
        chk("fetch_c1_mem", {mem_req, mem_we, stall, if_done}, 4'b1010);
        chk("fetch_c1_addr", mem_addr, 32'h40);
        @(negedge clk);
        chk("fetch_c2_done", {if_done, err, stall}, 3'b100);
        @(posedge clk); #1; if_req = 1'b0;

        // Simultaneous requests: data first, fetch three cycles later.
        raise_if(32'h80);
        raise_d(1'b0, 32'h100, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("simul_first_addr", {mem_req, mem_addr}, {1'b1, 32'h100});
        wait_done(1'b1, n);
        chk("simul_d_latency", n, 1);
        @(posedge clk); #1; d_req = 1'b0;
        wait_done(1'b0, n);
        chk("simul_if_after_d", n, 3);
        @(posedge clk); #1; if_req = 1'b0;

        // Store held on the memory port until ready, then read back.
        force_lat = 2;
        raise_d(1'b1, 32'h20, 32'h1234_5678);
        nreq = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                chk("store_mem_port", {mem_we, mem_wdata}, {1'b1, 32'h1234_5678});
            end
            if (d_done) got = 1;
        end
        chk("store_access_cycles", nreq, 3);
        @(posedge clk); #1; d_req = 1'b0;
        raise_d(1'b0, 32'h20, 32'h0);
        wait_done(1'b1, n);
        @(posedge clk); #1; d_req = 1'b0;

        // Starvation: both requesters held, data re-raised at once.
        force_lat = 0;
        for (int r = 0; r < 2; r++) begin
            raise_d(1'b0, 32'h4000 + 32'(r * 64), 32'h0);
            raise_if(32'h0C0 + 32'(r * 4));
            nd = 0; got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (d_done) begin
                    nd++;
                    @(posedge clk); #1;
                    raise_d(1'b0, 32'h4004 + 32'(r * 64 + nd * 4), 32'h0);
                end else if (if_done) begin
                    got = 1;
                    @(posedge clk); #1;
                end
            end
            if_req = 1'b0;
            chk("starve_d_grants_before_if", nd, MAX_STREAK);
            wait_done(1'b1, n);
            @(posedge clk); #1; d_req = 1'b0;
        end

        // Timeout: dead location, watchdog ends the access.
        force_lat = -1;
        raise_d(1'b0, 32'h10200, 32'h0);
        nreq = 0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (mem_req) nreq++;
            if (d_done) got = 1;
        end
        chk("tmo_mem_req_cycles", nreq, TIMEOUT);
        chk("tmo_done_seen", got, 1);
        @(posedge clk); #1; d_req = 1'b0;
        force_lat = 0;
        raise_if(32'h44);
        wait_done(1'b0, n);
        chk("tmo_bus_err_sticky", {bus_err, err}, 2'b10);
        @(posedge clk); #1; if_req = 1'b0;

        // Reset in the third cycle of a data access.
        force_lat = -1;
        raise_d(1'b0, 32'h10300, 32'h0);
        nreq = 0;
        for (int k = 0; k < 10 && nreq < 3; k++) begin
            @(negedge clk);
            if (mem_req) nreq++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_access", {mem_req, d_done, bus_err}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0;
        dq.delete();
        force_lat = 0;
        raise_if(32'h48);
        wait_done(1'b0, n);
        chk("rst_fresh_fetch_latency", n, 3);
        @(posedge clk); #1; if_req = 1'b0;

        // Randomized traffic from both requesters.
        force_lat = -1;
        fork
            rand_fetch();
            rand_data();
        join
        repeat (5) @(negedge clk);
        chk("ifq_drained", ifq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
